// File: rtl/lifo_stack_if.sv
// Bundled control/status signals of the lifo_stack backtracking store.
// LIFO_STACK_WATERMARK_EN adds the max_level high-water-mark signal.
interface lifo_stack_if #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Handshake: a request (push and/or pop) is sampled on every rising edge.
  // No ready back-pressure exists. Acceptance is reported one cycle later
  // by push_ack/pop_ack. A refused request leaves both acks low and sets
  // the matching sticky error flag.
  logic             clear;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             push_ack;
  logic             pop_ack;
  logic             overflow;
  logic             underflow;
`ifdef LIFO_STACK_WATERMARK_EN
  logic [CW-1:0]    max_level;
`endif

  modport master (
    output clear, push, pop, data_in,
    input  data_out, count, empty, full, push_ack, pop_ack, overflow, underflow
`ifdef LIFO_STACK_WATERMARK_EN
    , input max_level
`endif
  );

  modport slave (
    input  clear, push, pop, data_in,
    output data_out, count, empty, full, push_ack, pop_ack, overflow, underflow
`ifdef LIFO_STACK_WATERMARK_EN
    , output max_level
`endif
  );
endinterface

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with registered top-of-stack, replace-top, acks and sticky errors.
// Optional feature macro: LIFO_STACK_WATERMARK_EN (adds max_level high-water mark).
module lifo_stack #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8
) (
  input logic        clk,
  input logic        reset,
  lifo_stack_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count_q, count_d, wr_idx, below_idx;
  logic [WIDTH-1:0] dout_q, dout_d, below_val;
  logic             pack_q, pack_d, qack_q, qack_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             wr_en;

  // Entry just under the top; becomes the new top-of-stack on a pop.
  always_comb begin
    below_idx = count_q - CW'(2);
    below_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count_q >= CW'(2) && below_idx == CW'(i)) below_val = mem[i];
    end
  end

  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    pack_d  = 1'b0;
    qack_d  = 1'b0;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    wr_en   = 1'b0;
    wr_idx  = count_q;
    unique case ({bus.push, bus.pop})
      2'b10: begin
        if (count_q != DEPTH_C) begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
          dout_d  = bus.data_in;
          pack_d  = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      2'b01: begin
        if (count_q != '0) begin
          count_d = count_q - CW'(1);
          dout_d  = below_val;
          qack_d  = 1'b1;
        end else begin
          udf_d = 1'b1;
        end
      end
      2'b11: begin
        // Replace-top when non-empty; on an empty stack it degrades to a push.
        wr_en  = 1'b1;
        dout_d = bus.data_in;
        pack_d = 1'b1;
        if (count_q != '0) begin
          wr_idx = count_q - CW'(1);
          qack_d = 1'b1;
        end else begin
          count_d = CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      dout_q  <= '0;
      pack_q  <= 1'b0;
      qack_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else if (bus.clear) begin
      count_q <= '0;
      dout_q  <= '0;
      pack_q  <= 1'b0;
      qack_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      pack_q  <= pack_d;
      qack_q  <= qack_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // wr_idx is always < DEPTH: pushes only happen below full, replaces hit count-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!bus.clear && wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_idx == CW'(i)) mem[i] <= bus.data_in;
      end
    end
  end

`ifdef LIFO_STACK_WATERMARK_EN
  logic [CW-1:0] max_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_q <= '0;
    end else if (bus.clear) begin
      max_q <= '0;
    end else if (count_d > max_q) begin
      max_q <= count_d;
    end
  end

  assign bus.max_level = max_q;
`endif

  assign bus.data_out  = dout_q;
  assign bus.count     = count_q;
  assign bus.empty     = (count_q == '0);
  assign bus.full      = (count_q == DEPTH_C);
  assign bus.push_ack  = pack_q;
  assign bus.pop_ack   = qack_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
endmodule

// File: tb/tb_lifo_stack.sv
// Directed scoreboard bench for lifo_stack (DEPTH=8, WIDTH=6).
// Build with LIFO_STACK_WATERMARK_EN to also exercise max_level.
module tb_lifo_stack;
  localparam int WIDTH = 6;
  localparam int DEPTH = 8;
  localparam int EW    = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   step;

  logic [EW-1:0] exp_q[$];
  int            step_q[$];

  lifo_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs: {count, data_out, push_ack, pop_ack, overflow, underflow, empty, full}
  function automatic logic [EW-1:0] observed();
    return {bus.count, bus.data_out, bus.push_ack, bus.pop_ack,
            bus.overflow, bus.underflow, bus.empty, bus.full};
  endfunction

  function automatic logic [EW-1:0] pk(input int c, input logic [WIDTH-1:0] d,
                                       input logic pa, input logic qa,
                                       input logic ov, input logic un);
    logic [3:0] cc;
    cc = c[3:0];
    return {cc, d, pa, qa, ov, un, (c == 0), (c == DEPTH)};
  endfunction

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic op(input logic c, input logic p, input logic q, input logic [WIDTH-1:0] din,
                    input int ecount, input logic [WIDTH-1:0] edout,
                    input logic epa, input logic eqa, input logic eov, input logic eun);
    bus.clear   = c;
    bus.push    = p;
    bus.pop     = q;
    bus.data_in = din;
    @(posedge clk);
    step++;
    exp_q.push_back(pk(ecount, edout, epa, eqa, eov, eun));
    step_q.push_back(step);
    #1;
    bus.clear   = 1'b0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      int            s;
      e = exp_q.pop_front();
      s = step_q.pop_front();
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL step %0d: got %h expected %h (count,dout,pack,qack,ovf,udf,empty,full)",
                 s, observed(), e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks      = 0;
    errors      = 0;
    step        = 0;
    reset       = 1'b1;
    bus.clear   = 1'b0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_state", observed(), pk(0, 6'd0, 0, 0, 0, 0));

    // Fill 1..8 back to back.
    for (int i = 1; i <= 8; i++) op(0, 1, 0, 6'(i), i, 6'(i), 1, 0, 0, 0);
    // Push while full: refused, overflow sticks.
    op(0, 1, 0, 6'd9, 8, 6'd8, 0, 0, 1, 0);
    // Drain: top walks 7..0.
    for (int k = 7; k >= 0; k--) op(0, 0, 1, 6'd0, k, 6'(k), 0, 1, 1, 0);
    // Pop while empty: refused, underflow sticks.
    op(0, 0, 1, 6'd0, 0, 6'd0, 0, 0, 1, 1);
    // Clear wins over a simultaneous push.
    op(1, 1, 0, 6'd33, 0, 6'd0, 0, 0, 0, 0);

    // Replace-top.
    op(0, 1, 0, 6'd5,  1, 6'd5,  1, 0, 0, 0);
    op(0, 1, 0, 6'd9,  2, 6'd9,  1, 0, 0, 0);
    op(0, 1, 1, 6'd12, 2, 6'd12, 1, 1, 0, 0);
    op(0, 0, 1, 6'd0,  1, 6'd5,  0, 1, 0, 0);
    op(0, 0, 1, 6'd0,  0, 6'd0,  0, 1, 0, 0);
    // Idle holds state with acks low.
    op(0, 0, 0, 6'd17, 0, 6'd0,  0, 0, 0, 0);
    // Push+pop on empty acts as plain push, no underflow.
    op(0, 1, 1, 6'd3,  1, 6'd3,  1, 0, 0, 0);

    // Asynchronous reset mid-cycle.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", observed(), pk(0, 6'd0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;

    // Watermark sequence: push 5, pop 3, push 1.
    for (int i = 1; i <= 5; i++) op(0, 1, 0, 6'(i), i, 6'(i), 1, 0, 0, 0);
    op(0, 0, 1, 6'd0, 4, 6'd4, 0, 1, 0, 0);
    op(0, 0, 1, 6'd0, 3, 6'd3, 0, 1, 0, 0);
    op(0, 0, 1, 6'd0, 2, 6'd2, 0, 1, 0, 0);
    op(0, 1, 0, 6'd7, 3, 6'd7, 1, 0, 0, 0);
`ifdef LIFO_STACK_WATERMARK_EN
    @(negedge clk);
    check("max_level_5", 16'(bus.max_level), 16'd5);
`endif
    op(1, 0, 0, 6'd0, 0, 6'd0, 0, 0, 0, 0);
`ifdef LIFO_STACK_WATERMARK_EN
    @(negedge clk);
    check("max_level_clear", 16'(bus.max_level), 16'd0);
`endif

    // Bounded drain of the scoreboard.
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", exp_q.size());
    end
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Parametrised LIFO stack that generalises the fixed 8x6 stack used by the 8-queen search engine.
- Adds configurable width and depth, registered top-of-stack output, a simultaneous push+pop (replace-top) operation, synchronous clear, per-operation acknowledge pulses, and sticky overflow/underflow error flags.
- Sits between the search controller and the bus as the backtracking store.

Parameters:
WIDTH, 6, bits per entry
DEPTH, 8, number of entries (>=2; need not be a power of two)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
clear  input  1  synchronous flush of stack and error flags
push  input  1  push request
pop  input  1  pop request
data_in  input  WIDTH  value to push / replace
data_out  output  WIDTH  registered top-of-stack value, 0 when empty
count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH
empty  output  1  count==0
full  output  1  count==DEPTH
push_ack  output  1  one-cycle pulse: previous-cycle push (or replace) accepted
pop_ack  output  1  one-cycle pulse: previous-cycle pop (or replace) accepted
overflow  output  1  sticky: push-only attempted while full
underflow  output  1  sticky: pop-only attempted while empty

Behaviour:
- Reset (async, active-high): count=0, data_out=0, push_ack=pop_ack=0, overflow=underflow=0, all memory entries 0.
- empty and full are combinational decodes of count. All other outputs are registered.
- Priority per edge: clear > operation decode. While clear=1:
  - count<=0, data_out<=0, error flags<=0, acks<=0.
  - push/pop are ignored; memory contents are don't-care.
- Operation decode, with c = current count:
  - push=1, pop=0, c<DEPTH: mem[c]<=data_in; count<=c+1; data_out<=data_in; push_ack<=1.
  - push=1, pop=0, c==DEPTH: no state change; overflow<=1; push_ack<=0.
  - push=0, pop=1, c>0: count<=c-1; data_out<=(c>=2 ? mem[c-2] : 0); pop_ack<=1.
  - push=0, pop=1, c==0: no state change; underflow<=1; pop_ack<=0.
  - push=1, pop=1, c>0 (including full): replace top. mem[c-1]<=data_in; count unchanged; data_out<=data_in; push_ack<=1; pop_ack<=1. No error.
  - push=1, pop=1, c==0: treated as a plain push. count<=1; data_out<=data_in; push_ack<=1; pop_ack<=0. No underflow.
  - push=0, pop=0: hold all state; acks<=0.
- Latency: data_out and count reflect an operation on the edge at which it is sampled (visible in the next cycle). Acks assert for exactly one cycle after an accepted operation.
- Back-to-back operations every cycle are supported with no bubbles.
- Error flags are sticky until reset or clear. Refused operations never modify memory or count.
- Arithmetic: the count never wraps; it is bounded 0..DEPTH by the decode above. Indexing uses only in-range addresses.
- Reset asserted mid-operation aborts it immediately; there is no partial write.

Optional Feature:
- Macro: LIFO_STACK_WATERMARK_EN.
- Defined:
  - Adds output port max_level (width $clog2(DEPTH)+1), a registered high-water mark of count.
  - Updated to the new count whenever the new count exceeds max_level.
  - Cleared to 0 by reset and by clear.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- DEPTH=8, WIDTH=6. After reset, push 8 values 1..8 on consecutive cycles -> count steps 1..8; data_out follows each value; full=1 after the 8th; push_ack high 8 cycles.
- From full, push-only 9 -> count stays 8, data_out=8, overflow=1, push_ack=0. Then pop 8 times -> data_out 7,6,...,1,0; empty=1; overflow still 1.
- From empty, pop-only -> underflow=1, count=0, pop_ack=0. Then clear pulse -> overflow=underflow=0.
- Push 5, push 9, then push+pop with data_in=12 -> count=2, data_out=12, push_ack=pop_ack=1. Pop -> data_out=5.
- Empty stack, push+pop with data_in=3 -> count=1, data_out=3, pop_ack=0, no underflow. Assert reset asynchronously mid-cycle -> all outputs 0 before the next edge.
- With LIFO_STACK_WATERMARK_EN: push 5, pop 3, push 1 -> max_level=5. clear -> max_level=0.
